fc8_ram_arbiter: RTL and testbench
==================================

Name: fc8_ram_arbiter

Overview:
- Shares the single-port fc8 work RAM between two requesters: port 0 (CPU) and port 1 (DMA/video fetch).
- Sits between the requesters and the RAM physical interface.
- Issues at most one RAM access per cycle and returns registered read data one cycle after issue.
- Supports a bounded lock so one port can hold the RAM for atomic read-modify-write sequences.

Parameters:
- ADDR_WIDTH, 15, RAM address width (32KB).
- DATA_WIDTH, 8, data width.
- MAX_LOCK, 16, maximum consecutive cycles a port may hold a lock before forced release. Must be >= 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req0 / req1  in  1  access request, held until granted.
- we0 / we1  in  1  1 = write, 0 = read.
- lock0 / lock1  in  1  keep ownership after this grant.
- addr0 / addr1  in  ADDR_WIDTH  request address.
- wdata0 / wdata1  in  DATA_WIDTH  write data.
- gnt0 / gnt1  out  1  combinational; the request is issued to RAM this cycle.
- rvalid0 / rvalid1  out  1  registered; read data valid this cycle.
- rdata0 / rdata1  out  DATA_WIDTH  read data, meaningful only while the matching rvalid is high.
- lock_err  out  1  sticky; a lock timeout has occurred.
- phy_addr_out  out  ADDR_WIDTH  RAM address.
- phy_data_out  out  DATA_WIDTH  RAM write data.
- phy_wr_en  out  1  RAM write enable.
- phy_cs_en  out  1  RAM chip select.
- phy_data_in  in  DATA_WIDTH  RAM registered read data.

Behaviour:
- Reset and outputs:
  - Reset is asynchronous and active-low on rst_n; all registers are clocked by clk.
  - Reset values: state = IDLE, rr_ptr = 0, lock_cnt = 0, rvalid0/1 = 0, lock_err = 0.
  - While rst_n is low, gnt0/1, phy_cs_en and phy_wr_en are forced to 0.
  - When no grant is given, phy_addr_out and phy_data_out are 0.
- RAM drive: phy_cs_en = gnt0 | gnt1. Address, write enable and write data come from the granted port.
- States:
  - IDLE: arbitration between both ports.
  - OWN0: only port 0 may be granted.
  - OWN1: only port 1 may be granted.
- Arbitration in IDLE:
  - A single requester is granted.
  - If both request, port 0 wins (see Optional Feature for the alternative).
- Transitions:
  - IDLE -> OWNn at the edge where gntn is high and lockn is high.
  - OWNn -> IDLE at the edge where lockn is low. A request in that same cycle is still granted to port n.
  - While in OWNn, the other port's req is ignored, with gnt held at 0 and the request left pending.
- Lock timeout:
  - lock_cnt clears on entry to OWNn and increments every cycle in OWNn.
  - When lock_cnt == MAX_LOCK-1, the next edge forces IDLE and sets lock_err.
  - lock_err clears only on reset.
  - Re-entry is allowed on a later grant.
- Read return:
  - rvalidn is registered: rvalidn <= gntn & ~wen.
  - rdatan = phy_data_in, passed combinationally.
  - Latency is 1 cycle, with back-to-back reads at full throughput.
  - Writes produce no response.
- Same-address read after write is safe: the read is issued in a later cycle.
- Reset mid-operation: a pending rvalid is dropped, the lock is released and lock_err is cleared. No partial access is issued.

Optional Feature:
- Macro: FC8_RAM_ARB_RR_EN.
- Defined: IDLE contention uses round-robin.
  - rr_ptr names the preferred port; after any grant in IDLE, rr_ptr <= the other port.
  - Grants inside OWNn do not update rr_ptr.
- Undefined: fixed priority, port 0 always wins; the rr_ptr register is omitted.

Decomposition:
- fc8_defines.v holds:
  - state encodings FC8_ARB_IDLE = 2'd0, FC8_ARB_OWN0 = 2'd1, FC8_ARB_OWN1 = 2'd2;
  - port ids FC8_ARB_P0 / FC8_ARB_P1.
- One sub-module, fc8_arb_pick2: combinational two-way picker with inputs req[1:0], pref and mask[1:0] and a one-hot grant output. It is reused by later bus arbiters.

Test Plan:
- Reset values: assert rst_n = 0 mid-read -> rvalid0/1 = 0, phy_cs_en = 0, lock_err = 0, state IDLE.
- Single read: req1 = 1, we1 = 0, addr1 = 0x0123, with RAM holding 0x5A -> gnt1 in cycle T, rvalid1 = 1 and rdata1 = 0x5A in T+1.
- Contention, fixed priority: req0 and req1 both held 3 cycles -> gnt0 for 3 cycles, gnt1 = 0. With FC8_RAM_ARB_RR_EN: grants go 0, 1, 0.
- Lock hold: port 0 reads 0x0010 with lock0 = 1, then writes 0x0010 = 0xA5 with lock0 = 0 while req1 is held -> gnt1 = 0 until the edge after the write, then gnt1 = 1.
- Lock timeout: MAX_LOCK = 4, lock0 held high indefinitely, req1 = 1 -> forced IDLE after 4 cycles in OWN0, lock_err = 1, port 1 granted in IDLE, lock_err still 1 after 20 further cycles.
- Back-to-back: port 0 writes 0x7FFF = 0x3C then reads 0x7FFF next cycle -> rvalid0 with rdata0 = 0x3C two cycles after the write grant.

Source files
------------

// File: rtl/fc8_ram_arbiter_pkg.sv
// fc8 work-RAM arbiter shared definitions.
// State encodings and port ids used by the arbiter and its picker.
package fc8_ram_arbiter_pkg;

    typedef enum logic [1:0] {
        FC8_ARB_IDLE = 2'd0,
        FC8_ARB_OWN0 = 2'd1,
        FC8_ARB_OWN1 = 2'd2
    } arb_state_e;

    localparam logic FC8_ARB_P0 = 1'b0;
    localparam logic FC8_ARB_P1 = 1'b1;

endpackage

// File: rtl/fc8_ram_arbiter_pick2.sv
// fc8_arb_pick2: combinational two-way picker with a preferred port
// and a per-port mask; grant output is one-hot or zero.
module fc8_arb_pick2
    import fc8_ram_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       pref,
    input  logic [1:0] mask,
    output logic [1:0] gnt
);

    logic [1:0] live;

    // Masked requests; contention resolved toward the preferred port.
    always_comb begin
        live = req & mask;
        gnt  = live;
        if (live == 2'b11) begin
            gnt = (pref == FC8_ARB_P1) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/fc8_ram_arbiter.sv
// fc8_ram_arbiter: two-port arbiter for the single-port fc8 work RAM.
// Define FC8_RAM_ARB_RR_EN for round-robin contention (else port 0 wins).
module fc8_ram_arbiter
    import fc8_ram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_LOCK   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic                  lock0,
    input  logic                  lock1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  lock_err,
    output logic [ADDR_WIDTH-1:0] phy_addr_out,
    output logic [DATA_WIDTH-1:0] phy_data_out,
    output logic                  phy_wr_en,
    output logic                  phy_cs_en,
    input  logic [DATA_WIDTH-1:0] phy_data_in
);

    localparam int CW = $clog2(MAX_LOCK);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LOCK - 1);

    arb_state_e    state_q, state_d;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;
    logic          lock_err_q, lock_err_d;
    logic          pref;
    logic [1:0]    mask;
    logic [1:0]    pick;

`ifdef FC8_RAM_ARB_RR_EN
    logic rr_ptr_q, rr_ptr_d;

    // Preferred port rotates after every grant made in IDLE.
    always_comb begin
        pref     = rr_ptr_q;
        rr_ptr_d = rr_ptr_q;
        if (state_q == FC8_ARB_IDLE && (gnt0 || gnt1)) begin
            rr_ptr_d = gnt0 ? FC8_ARB_P1 : FC8_ARB_P0;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr_q <= FC8_ARB_P0;
        else        rr_ptr_q <= rr_ptr_d;
    end
`else
    assign pref = FC8_ARB_P0;
`endif

    // Owner state restricts which port the picker may grant.
    always_comb begin
        unique case (state_q)
            FC8_ARB_OWN0: mask = 2'b01;
            FC8_ARB_OWN1: mask = 2'b10;
            default:      mask = 2'b11;
        endcase
    end

    fc8_arb_pick2 u_pick (
        .req  ({req1, req0}),
        .pref (pref),
        .mask (mask),
        .gnt  (pick)
    );

    assign gnt0 = rst_n & pick[0];
    assign gnt1 = rst_n & pick[1];

    // RAM drive muxed from the granted port; idle bus is all zero.
    always_comb begin
        phy_cs_en    = gnt0 | gnt1;
        phy_wr_en    = (gnt0 & we0) | (gnt1 & we1);
        phy_addr_out = '0;
        phy_data_out = '0;
        if (gnt0) begin
            phy_addr_out = addr0;
            phy_data_out = wdata0;
        end else if (gnt1) begin
            phy_addr_out = addr1;
            phy_data_out = wdata1;
        end
    end

    // Lock ownership, bounded hold timer and read-return tracking.
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        lock_err_d = lock_err_q;
        rvalid0_d  = gnt0 & ~we0;
        rvalid1_d  = gnt1 & ~we1;
        unique case (state_q)
            FC8_ARB_IDLE: begin
                if (gnt0 && lock0) begin
                    state_d    = FC8_ARB_OWN0;
                    lock_cnt_d = '0;
                end else if (gnt1 && lock1) begin
                    state_d    = FC8_ARB_OWN1;
                    lock_cnt_d = '0;
                end
            end
            FC8_ARB_OWN0: begin
                if (lock_cnt_q == CNT_MAX) begin
                    state_d    = FC8_ARB_IDLE;
                    lock_err_d = 1'b1;
                end else if (!lock0) begin
                    state_d = FC8_ARB_IDLE;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            FC8_ARB_OWN1: begin
                if (lock_cnt_q == CNT_MAX) begin
                    state_d    = FC8_ARB_IDLE;
                    lock_err_d = 1'b1;
                end else if (!lock1) begin
                    state_d = FC8_ARB_IDLE;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            default: state_d = FC8_ARB_IDLE;
        endcase
    end

    // State, timer, sticky error and read-valid registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FC8_ARB_IDLE;
            lock_cnt_q <= '0;
            lock_err_q <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            lock_err_q <= lock_err_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
        end
    end

    assign rvalid0  = rvalid0_q;
    assign rvalid1  = rvalid1_q;
    assign lock_err = lock_err_q;
    assign rdata0   = phy_data_in;
    assign rdata1   = phy_data_in;

endmodule

// File: tb/tb_fc8_ram_arbiter.sv
// Directed self-checking bench for fc8_ram_arbiter (MAX_LOCK = 4)
// with a registered-read RAM model on the physical side.
module tb_fc8_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [14:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, lock_err;
    logic [7:0]  rdata0, rdata1;
    logic [14:0] phy_addr_out;
    logic [7:0]  phy_data_out;
    logic        phy_wr_en, phy_cs_en;
    logic [7:0]  phy_data_in;
    logic [7:0]  mem [0:32767];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fc8_ram_arbiter #(
        .ADDR_WIDTH (15),
        .DATA_WIDTH (8),
        .MAX_LOCK   (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0         (req0),
        .req1         (req1),
        .we0          (we0),
        .we1          (we1),
        .lock0        (lock0),
        .lock1        (lock1),
        .addr0        (addr0),
        .addr1        (addr1),
        .wdata0       (wdata0),
        .wdata1       (wdata1),
        .gnt0         (gnt0),
        .gnt1         (gnt1),
        .rvalid0      (rvalid0),
        .rvalid1      (rvalid1),
        .rdata0       (rdata0),
        .rdata1       (rdata1),
        .lock_err     (lock_err),
        .phy_addr_out (phy_addr_out),
        .phy_data_out (phy_data_out),
        .phy_wr_en    (phy_wr_en),
        .phy_cs_en    (phy_cs_en),
        .phy_data_in  (phy_data_in)
    );

    // RAM model: synchronous write, registered read data.
    always @(posedge clk) begin
        if (phy_cs_en && phy_wr_en) mem[phy_addr_out] <= phy_data_out;
        if (phy_cs_en && !phy_wr_en) phy_data_in <= mem[phy_addr_out];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic e0, e1;
        rst_n = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        mem[15'h0123] = 8'h5A;

        // Reset: outputs quiet, request ignored.
        req0 = 1;
        tick(); tick();
        chk("rst_gnt0", gnt0, 0);
        chk("rst_cs", phy_cs_en, 0);
        chk("rst_rv0", rvalid0, 0);
        chk("rst_rv1", rvalid1, 0);
        chk("rst_lockerr", lock_err, 0);
        chk("rst_addr", phy_addr_out, 0);
        req0 = 0;
        rst_n = 1;
        tick();

        // Single read from port 1.
        req1 = 1; we1 = 0; addr1 = 15'h0123;
        #1;
        chk("rd_gnt1", gnt1, 1);
        chk("rd_addr", phy_addr_out, 15'h0123);
        chk("rd_cs", phy_cs_en, 1);
        chk("rd_we", phy_wr_en, 0);
        tick();
        req1 = 0;
        #1;
        chk("rd_rv1", rvalid1, 1);
        chk("rd_data1", rdata1, 8'h5A);
        chk("rd_idle_cs", phy_cs_en, 0);
        chk("rd_idle_addr", phy_addr_out, 0);

        // Contention for three cycles.
        req0 = 1; req1 = 1; addr0 = 15'h1; addr1 = 15'h2;
        for (int i = 0; i < 3; i++) begin
`ifdef FC8_RAM_ARB_RR_EN
            e0 = (i != 1);
`else
            e0 = 1'b1;
`endif
            e1 = ~e0;
            #1;
            chk("cont_gnt0", gnt0, e0);
            chk("cont_gnt1", gnt1, e1);
            tick();
        end
        req0 = 0; req1 = 0;
        chk("cont_rv0", rvalid0, 1);

        // Locked read-modify-write by port 0.
        req0 = 1; we0 = 0; lock0 = 1; addr0 = 15'h0010;
        #1;
        chk("lk_gnt0_a", gnt0, 1);
        tick();
        we0 = 1; wdata0 = 8'hA5; lock0 = 0;
        req1 = 1; we1 = 0; addr1 = 15'h0020;
        #1;
        chk("lk_gnt0_b", gnt0, 1);
        chk("lk_gnt1_b", gnt1, 0);
        chk("lk_wr_en", phy_wr_en, 1);
        chk("lk_wdata", phy_data_out, 8'hA5);
        chk("lk_rv0", rvalid0, 1);
        tick();
        req0 = 0; we0 = 0;
        #1;
        chk("lk_gnt1_c", gnt1, 1);
        chk("lk_wr_norv", rvalid0, 0);
        tick();
        req1 = 0;
        #1;
        chk("lk_rv1", rvalid1, 1);

        // Lock timeout with lock0 held forever.
        req0 = 1; we0 = 0; lock0 = 1; addr0 = 15'h5;
        req1 = 1;
        #1;
        chk("to_gnt0", gnt0, 1);
        tick();
        req0 = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("to_own_gnt1", gnt1, 0);
            chk("to_own_err", lock_err, 0);
            tick();
        end
        chk("to_err", lock_err, 1);
        chk("to_gnt1", gnt1, 1);
        tick();
        req1 = 0;
        repeat (20) tick();
        chk("to_err_sticky", lock_err, 1);
        lock0 = 0;

        // Back-to-back write then read of the top address.
        req0 = 1; we0 = 1; addr0 = 15'h7FFF; wdata0 = 8'h3C;
        #1;
        chk("bb_gnt_w", gnt0, 1);
        chk("bb_we", phy_wr_en, 1);
        tick();
        we0 = 0;
        #1;
        chk("bb_gnt_r", gnt0, 1);
        chk("bb_rd", phy_wr_en, 0);
        tick();
        req0 = 0;
        #1;
        chk("bb_rv0", rvalid0, 1);
        chk("bb_data0", rdata0, 8'h3C);

        // Reset in the middle of a locked read.
        req1 = 1; we1 = 0; lock1 = 1; addr1 = 15'h0123;
        #1;
        chk("mr_gnt1", gnt1, 1);
        rst_n = 0;
        #1;
        chk("mr_gnt1_rst", gnt1, 0);
        chk("mr_cs_rst", phy_cs_en, 0);
        chk("mr_err_clr", lock_err, 0);
        tick();
        chk("mr_rv1", rvalid1, 0);
        rst_n = 1;
        req1 = 0; lock1 = 0;
        req0 = 1; we0 = 0; addr0 = 15'h0123;
        #1;
        chk("mr_idle_gnt0", gnt0, 1);
        tick();
        req0 = 0;
        #1;
        chk("mr_rv0", rvalid0, 1);
        chk("mr_data0", rdata0, 8'h5A);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
